uart_word_rx: RTL and testbench
===============================

Name: uart_word_rx

Overview:
- Parametrised UART receiver and byte-to-word packer. Turns the host serial stream into instruction/data words for the SoC command decoder.
- Successor to the fixed 8-bit, odd-parity, 4-byte receive path. Adds configurable data bits, parity mode, word size and inter-byte timeout.
- Adds explicit error reporting and a valid/ready output handshake.
- Sits between the `rx` pad and the instruction/data dispatch logic.

Parameters:
- CLKS_PER_BIT, 10: clock cycles per UART bit; must be >= 4.
- DATA_BITS, 8: data bits per character, 5..8.
- PARITY_MODE, 1: 0 = none, 1 = odd, 2 = even.
- BYTES_PER_WORD, 4: characters packed per output word, 1..8.
- TIMEOUT_BITS, 32: idle bit-times after a character before a partial word is discarded.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- word_data  out  DATA_BITS*BYTES_PER_WORD  packed word; first character received is in the LSBs.
- word_valid  out  1  word available.
- word_ready  in  1  consumer accepts the word when word_valid && word_ready.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed word was dropped because the output was still held.
- timeout  out  1  one-cycle pulse: partial word discarded after idle.
- err_count  out  16  saturating error counter; see Optional Feature.

Behaviour:
- Reset is synchronous, active-high, and takes priority over all other logic.
- Reset values:
  - All outputs 0; word_data = 0.
  - rx synchroniser flops = 1.
  - FSM in IDLE; packer and timeout counter cleared.
- Reset mid-frame: the character is abandoned and no error pulse is generated.
- Input synchronisation: rx passes through 2 flops (rx_s). All detection uses rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on rx_s == 0. Bit counter loads CLKS_PER_BIT/2.
  - START: at mid-bit, if rx_s == 1 it is a false start -> IDLE with no error. Otherwise -> DATA.
  - DATA: sample rx_s every CLKS_PER_BIT cycles, DATA_BITS times, LSB first. Then -> PARITY, or -> STOP when PARITY_MODE == 0.
  - PARITY: sample one bit.
    - Odd mode requires XOR(data, parity) = 1.
    - Even mode requires XOR(data, parity) = 0.
    - Then -> STOP.
  - STOP: sample at mid-bit, then -> IDLE immediately. The next start edge may be detected on the following cycle (second half of the stop bit).
- Character acceptance:
  - Good stop and good parity: the character is written into the packer slot at index byte_idx; byte_idx increments.
  - Parity error: parity_err pulses the cycle after the stop sample; the character is dropped and the packer is cleared (byte_idx = 0).
  - Stop bit low: frame_err pulses; same discard.
  - Parity error and low stop bit together: both pulses are asserted in the same cycle.
- Word completion:
  - When byte_idx reaches BYTES_PER_WORD, word_data is loaded and word_valid = 1 on the cycle after the final stop sample; byte_idx = 0.
  - word_valid and word_data are held stable until the handshake.
  - word_valid drops the cycle after word_valid && word_ready.
  - If a new word completes while word_valid = 1 and word_ready = 0, the new word is dropped, overrun pulses, and the held word is unchanged.
  - If a new word completes in the same cycle as the handshake on the old word, the new word is loaded and no overrun is reported.
- Timeout:
  - Active while byte_idx != 0 and the FSM is in IDLE.
  - The counter counts cycles; at TIMEOUT_BITS*CLKS_PER_BIT, timeout pulses and byte_idx = 0.
  - The counter clears on any start detection.
- Width rules:
  - Bit counter width: clog2(CLKS_PER_BIT) + 1.
  - Timeout counter width: clog2(TIMEOUT_BITS*CLKS_PER_BIT) + 1.
  - byte_idx width: clog2(BYTES_PER_WORD) + 1.

Optional Feature:
- Macro: UART_WORD_RX_ERR_CNT_EN.
- Defined: err_count increments by 1 in any cycle where at least one of parity_err, frame_err, overrun or timeout pulses. It saturates at 0xFFFF and is cleared only by rst.
- Undefined: err_count is tied to 0 and no counter flops are built.

Test Plan:
- Common setup for all scenarios: defaults, clk period 100 ns, bit time 1000 ns.
- Basic word: send bytes 0x01, 0x13, 0x01, 0x60, odd parity, word_ready = 1.
  - Required: exactly one word_valid pulse with word_data = 0x60011301.
  - Required: no error pulses.
- Parity error: send 0x13 with a wrong parity bit, followed by the 4 good bytes of 0x80000000.
  - Required: parity_err pulses once.
  - Required: the next word is exactly 0x80000000.
  - With UART_WORD_RX_ERR_CNT_EN: err_count = 1.
- Backpressure and overrun: word_ready = 0; send 0xA0000000 then 0xA0000001.
  - Required: word_valid stays high with 0xA0000000 throughout.
  - Required: overrun pulses once after the second word completes.
  - Then raise word_ready: one handshake with 0xA0000000, then word_valid = 0.
- Timeout: send 2 bytes, then hold rx high for 40 bit-times, then send 4 bytes of 0xE0000000.
  - Required: timeout pulses once at 32 bit-times after the second stop sample.
  - Required: the next word is 0xE0000000.
- Glitch and frame error:
  - A 300 ns low glitch on rx: no state change, no pulse.
  - A character with the stop bit held low: frame_err pulses and the packer is cleared.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 of byte 2.
  - Required: all outputs 0 and no error pulse.
  - Required: the subsequent full word 0x60011301 is received correctly.

Source files
------------

// File: rtl/uart_word_rx.sv
// uart_word_rx: UART receiver packing characters into words; define UART_WORD_RX_ERR_CNT_EN to build err_count
module uart_word_rx #(
  parameter int CLKS_PER_BIT   = 10,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 1,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_BITS   = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rx,
  output logic [DATA_BITS*BYTES_PER_WORD-1:0] word_data,
  output logic                                word_valid,
  input  logic                                word_ready,
  output logic                                parity_err,
  output logic                                frame_err,
  output logic                                overrun,
  output logic                                timeout,
  output logic [15:0]                         err_count
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int TW = $clog2(TIMEOUT_BITS*CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(BYTES_PER_WORD) + 1;
  localparam int WW = DATA_BITS*BYTES_PER_WORD;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT-1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BITS*CLKS_PER_BIT-1);
  localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD-1);
  localparam logic [3:0] NB_LAST = 4'(DATA_BITS-1);
  logic                 r_rx_m, r_rx_s;
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_nbit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [WW-1:0]        r_pack, w_pack;
  logic [IW-1:0]        r_byte_idx;
  logic [TW-1:0]        r_to_cnt;
  logic w_tick, w_start, w_stop_smp, w_par_ok, w_good, w_last, w_complete, w_to_active;
  assign w_tick      = r_cnt == '0;
  assign w_start     = r_state == IDLE && !r_rx_s;
  assign w_stop_smp  = r_state == STOP && w_tick;
  assign w_par_ok    = (PARITY_MODE == 0) ? 1'b1 : ((^r_shift ^ r_par) == (PARITY_MODE == 1));
  assign w_good      = w_par_ok && r_rx_s;
  assign w_last      = r_byte_idx == LAST;
  assign w_complete  = w_stop_smp && w_good && w_last;
  assign w_to_active = r_state == IDLE && r_byte_idx != '0 && !w_start;
  always_comb begin
    w_pack = r_pack;
    w_pack[int'(r_byte_idx)*DATA_BITS +: DATA_BITS] = r_shift;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
    end
  end
  // Every sampling state counts down to zero and samples rx_s on the zero cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_nbit  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (!r_rx_s) begin
          r_state <= START;
          r_cnt   <= HALF;
        end
        START: if (w_tick) begin
          r_state <= r_rx_s ? IDLE : DATA;
          r_cnt   <= FULL;
          r_nbit  <= '0;
        end else r_cnt <= r_cnt - 1'b1;
        DATA: if (w_tick) begin
          r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
          r_cnt   <= FULL;
          r_nbit  <= r_nbit + 1'b1;
          if (r_nbit == NB_LAST) r_state <= (PARITY_MODE == 0) ? STOP : PARITY;
        end else r_cnt <= r_cnt - 1'b1;
        PARITY: if (w_tick) begin
          r_par   <= r_rx_s;
          r_state <= STOP;
          r_cnt   <= FULL;
        end else r_cnt <= r_cnt - 1'b1;
        STOP: if (w_tick) r_state <= IDLE;
        else r_cnt <= r_cnt - 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pack     <= '0;
      r_byte_idx <= '0;
      r_to_cnt   <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      parity_err <= w_stop_smp && !w_par_ok;
      frame_err  <= w_stop_smp && !r_rx_s;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      if (w_stop_smp) begin
        if (!w_good || w_last) r_byte_idx <= '0;
        else begin
          r_pack     <= w_pack;
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end
      if (w_to_active) begin
        r_to_cnt <= (r_to_cnt == TO_LAST) ? '0 : r_to_cnt + 1'b1;
        if (r_to_cnt == TO_LAST) begin
          timeout    <= 1'b1;
          r_byte_idx <= '0;
        end
      end else r_to_cnt <= '0;
      // A word finishing during the handshake of the held one replaces it
      if (w_complete) begin
        if (!word_valid || word_ready) begin
          word_data  <= w_pack;
          word_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (word_valid && word_ready) word_valid <= 1'b0;
    end
  end
`ifdef UART_WORD_RX_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if ((parity_err | frame_err | overrun | timeout) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: randomized bench for uart_word_rx against a byte-queue reference model
`timescale 1ns/1ps
module tb_uart_word_rx;
  localparam int BIT = 1000;
  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, word_ready = 1'b1;
  logic [31:0] word_data;
  logic        word_valid, parity_err, frame_err, overrun, timeout;
  logic [15:0] err_count;
  uart_word_rx dut (
    .clk(clk), .rst(rst), .rx(rx), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .timeout(timeout), .err_count(err_count)
  );
  always #50 clk = ~clk;
  int          n_chk = 0, n_pass = 0;
  int          n_par = 0, n_frm = 0, n_ovr = 0, n_to = 0, n_unstable = 0;
  realtime     t_to = 0;
  logic [31:0] got_q[$], exp_q[$];
  logic [7:0]  acc[$];
  bit          m_held = 0;
  int          m_err = 0;
  logic        prev_v = 0, prev_hs = 0;
  logic [31:0] prev_d = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (word_valid && word_ready) got_q.push_back(word_data);
    if (word_valid && prev_v && !prev_hs && word_data !== prev_d) n_unstable++;
    n_par += int'(parity_err);
    n_frm += int'(frame_err);
    n_ovr += int'(overrun);
    n_to  += int'(timeout);
    if (timeout) t_to = $realtime;
    prev_v  = word_valid;
    prev_hs = word_valid && word_ready;
    prev_d  = word_data;
  end
  function automatic int errs();
    return n_par + n_frm + n_ovr + n_to;
  endfunction
  function automatic int exp_cnt();
`ifdef UART_WORD_RX_ERR_CNT_EN
    return (m_err > 65535) ? 65535 : m_err;
`else
    return 0;
`endif
  endfunction
  task automatic model_char(input logic [7:0] b, input bit ok);
    logic [31:0] w;
    if (!ok) begin
      acc.delete();
      m_err++;
    end else begin
      acc.push_back(b);
      if (acc.size() == 4) begin
        w = {acc[3], acc[2], acc[1], acc[0]};
        acc.delete();
        if (m_held) m_err++;
        else begin
          exp_q.push_back(w);
          m_held = !word_ready;
        end
      end
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    rx = 1'b0;
    #BIT;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT;
    end
    rx = ~(^b) ^ bad_par;
    #BIT;
    rx = ~bad_stop;
    #BIT;
    rx = 1'b1;
    model_char(b, !(bad_par || bad_stop));
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0, 1'b0);
  endtask
  task automatic check_words(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int e0, u0;
    realtime te;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_pulses", {parity_err, frame_err, overrun, timeout}, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    e0 = errs();
    send_word(32'h60011301);
    #(2*BIT);
    check_words("basic");
    chk("basic_errs", errs() - e0, 0);
    e0 = n_par;
    send_byte(8'h13, 1'b1, 1'b0);
    send_word(32'h80000000);
    #(2*BIT);
    chk("par_pulse", n_par - e0, 1);
    check_words("parity");
    chk("par_err_count", err_count, exp_cnt());
    @(negedge clk) word_ready = 1'b0;
    e0 = n_ovr;
    u0 = n_unstable;
    send_word(32'hA0000000);
    #(2*BIT);
    chk("bp_valid", word_valid, 1);
    chk("bp_data", word_data, 32'hA0000000);
    send_word(32'hA0000001);
    #(2*BIT);
    chk("bp_valid_held", word_valid, 1);
    chk("bp_data_held", word_data, 32'hA0000000);
    chk("bp_overrun", n_ovr - e0, 1);
    chk("bp_stable", n_unstable - u0, 0);
    @(negedge clk) word_ready = 1'b1;
    m_held = 0;
    repeat (3) @(negedge clk);
    chk("bp_valid_drop", word_valid, 0);
    check_words("bp");
    e0 = n_to;
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    te = $realtime;
    #(40*BIT);
    chk("to_pulse", n_to - e0, 1);
    chk("to_window", (t_to - te >= 31.0*BIT) && (t_to - te <= 33.0*BIT), 1);
    acc.delete();
    m_err++;
    send_word(32'hE0000000);
    #(2*BIT);
    check_words("timeout");
    send_byte(8'h77, 1'b0, 1'b0);
    e0 = errs();
    rx = 1'b0;
    #300;
    rx = 1'b1;
    #(2*BIT);
    chk("glitch_errs", errs() - e0, 0);
    chk("glitch_valid", word_valid, 0);
    e0 = n_frm;
    send_byte(8'h55, 1'b0, 1'b1);
    #BIT;
    chk("frame_pulse", n_frm - e0, 1);
    send_word(32'h12345678);
    #(2*BIT);
    check_words("frame");
    for (int k = 0; k < 60 && exp_q.size() < 6; k++) begin
      b = 8'($urandom);
      send_byte(b, $urandom_range(0, 7) == 0, 1'b0);
    end
    #(2*BIT);
    check_words("random");
    chk("err_count", err_count, exp_cnt());
    e0 = errs();
    send_byte(8'h01, 1'b0, 1'b0);
    b = 8'h13;
    rx = 1'b0;
    #BIT;
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      #BIT;
    end
    rx = b[3];
    #(BIT/2);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    rx = 1'b1;
    chk("rmf_valid", word_valid, 0);
    chk("rmf_data", word_data, 0);
    chk("rmf_pulses", {parity_err, frame_err, overrun, timeout}, 0);
    chk("rmf_err_count", err_count, 0);
    acc.delete();
    m_held = 0;
    m_err = 0;
    check_words("pre_reset");
    #(12*BIT);
    send_word(32'h60011301);
    #(2*BIT);
    chk("rmf_no_err", errs() - e0, 0);
    check_words("after_reset");
    chk("final_err_count", err_count, exp_cnt());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
